// File: rtl/alarm_pkg.sv
// Shared alarm-controller types, BCD limits and BCD increment helpers.
package alarm_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SET_HOUR = 3'd1,
      SET_MIN  = 3'd2,
      RINGING  = 3'd3,
      SNOOZE   = 3'd4
   } alarm_state_t;

   localparam logic [3:0] HOUR_TENS_MAX   = 4'd2;
   localparam logic [3:0] HOUR_WRAP_UNITS = 4'd3;
   localparam logic [3:0] MIN_TENS_MAX    = 4'd5;
   localparam logic [3:0] UNITS_MAX       = 4'd9;

   function automatic logic [7:0] hour_inc(input logic [3:0] tens, input logic [3:0] units);
      logic [7:0] r;
      if (tens == HOUR_TENS_MAX && units == HOUR_WRAP_UNITS) begin
         r = 8'h00;
      end else if (units == UNITS_MAX) begin
         r = {tens + 4'd1, 4'd0};
      end else begin
         r = {tens, units + 4'd1};
      end
      return r;
   endfunction

   // Minute wraps 59 -> 00 on its own; the hour is never carried into.
   function automatic logic [7:0] min_inc(input logic [3:0] tens, input logic [3:0] units);
      logic [7:0] r;
      if (units != UNITS_MAX) begin
         r = {tens, units + 4'd1};
      end else if (tens == MIN_TENS_MAX) begin
         r = 8'h00;
      end else begin
         r = {tens + 4'd1, 4'd0};
      end
      return r;
   endfunction

endpackage

// File: rtl/alarm_ctrl_btn_edge.sv
// N-wide rising-edge detector; history resets high so a button held through reset is not a press.
module btn_edge
   import alarm_pkg::*;
#(
   parameter int N = 5
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] btn,
   output logic [N-1:0] press
);

   logic [N-1:0] btn_d_r;

   // Previous-cycle button levels.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         btn_d_r <= '1;
      end else begin
         btn_d_r <= btn;
      end
   end

   assign press = btn & ~btn_d_r;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: settable BCD alarm, match trigger, pulsed buzzer with snooze and timeout.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int ALARM_INIT_HOUR = 7,
   parameter int ALARM_INIT_MIN  = 0,
   parameter int SNOOZE_MIN      = 5,
   parameter int RING_MIN        = 1,
   parameter int BEEP_CYC        = 25000000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [3:0] hourdec_now,
   input  logic [3:0] hourone_now,
   input  logic [3:0] mindec_now,
   input  logic [3:0] minone_now,
   input  logic       btn_set,
   input  logic       btn_inc,
   input  logic       btn_arm,
   input  logic       btn_stop,
   input  logic       btn_snooze,
   output logic [3:0] alarm_hourdec,
   output logic [3:0] alarm_hourone,
   output logic [3:0] alarm_mindec,
   output logic [3:0] alarm_minone,
   output logic       alarm_en,
   output logic       disp_sel,
   output logic       blink_hour,
   output logic       blink_min,
   output logic       buzzer,
   output logic       ringing
);

   localparam int BW = $clog2(BEEP_CYC + 1);
   localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYC - 1);
   localparam logic [BW-1:0] BEEP_ONE  = BW'(1);
   localparam logic [3:0] INIT_HD = 4'(ALARM_INIT_HOUR / 10);
   localparam logic [3:0] INIT_HO = 4'(ALARM_INIT_HOUR % 10);
   localparam logic [3:0] INIT_MD = 4'(ALARM_INIT_MIN / 10);
   localparam logic [3:0] INIT_MO = 4'(ALARM_INIT_MIN % 10);

   alarm_state_t state_r, state_s;
   logic [3:0] ahd_r, aho_r, amd_r, amo_r;
   logic [3:0] ahd_s, aho_s, amd_s, amo_s;
   logic       en_r, en_s;
   logic [3:0] ring_cnt_r, ring_cnt_s, snooze_cnt_r, snooze_cnt_s;
   logic [BW-1:0] beep_cnt_r, beep_cnt_s;
   logic       buzzer_r, buzzer_s;
   logic [3:0] minone_d_r;
   logic       valid_r, match_d_r;
   logic [4:0] press_s;
   logic       do_stop_s, do_snooze_s, do_set_s, do_inc_s, do_arm_s;
   logic       minute_edge_s, match_s, trigger_s;

   btn_edge #(.N(5)) u_btn_edge (
      .clk   (clk),
      .rstn  (rstn),
      .btn   ({btn_snooze, btn_stop, btn_arm, btn_inc, btn_set}),
      .press (press_s)
   );

   // One action per cycle: stop > snooze > set > inc > arm.
   assign do_stop_s   = press_s[3];
   assign do_snooze_s = press_s[4] & ~press_s[3];
   assign do_set_s    = press_s[0] & ~(|press_s[4:3]);
   assign do_inc_s    = press_s[1] & ~press_s[0] & ~(|press_s[4:3]);
   assign do_arm_s    = press_s[2] & ~(|{press_s[4:3], press_s[1:0]});

   assign minute_edge_s = valid_r & (minone_now != minone_d_r);
   assign match_s   = en_r & (hourdec_now == ahd_r) & (hourone_now == aho_r)
                    & (mindec_now == amd_r) & (minone_now == amo_r);
   assign trigger_s = match_s & ~match_d_r;

   // Next-state and next-datapath logic.
   always_comb begin
      state_s      = state_r;
      ahd_s        = ahd_r;
      aho_s        = aho_r;
      amd_s        = amd_r;
      amo_s        = amo_r;
      en_s         = en_r;
      ring_cnt_s   = ring_cnt_r;
      snooze_cnt_s = snooze_cnt_r;
      beep_cnt_s   = beep_cnt_r;
      buzzer_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (trigger_s) begin
               state_s    = RINGING;
               ring_cnt_s = 4'(RING_MIN);
               beep_cnt_s = '0;
               buzzer_s   = 1'b1;
            end else if (do_set_s) begin
               state_s = SET_HOUR;
            end else if (do_arm_s) begin
               en_s = ~en_r;
            end else begin
               state_s = IDLE;
            end
         end
         SET_HOUR: begin
            if (do_set_s) begin
               state_s = SET_MIN;
            end else if (do_inc_s) begin
               {ahd_s, aho_s} = hour_inc(ahd_r, aho_r);
            end else begin
               state_s = SET_HOUR;
            end
         end
         SET_MIN: begin
            if (do_set_s) begin
               state_s = IDLE;
            end else if (do_inc_s) begin
               {amd_s, amo_s} = min_inc(amd_r, amo_r);
            end else begin
               state_s = SET_MIN;
            end
         end
         RINGING: begin
            if (do_stop_s) begin
               state_s = IDLE;
            end else if (do_snooze_s) begin
               state_s      = SNOOZE;
               snooze_cnt_s = 4'(SNOOZE_MIN);
            end else if (minute_edge_s && ring_cnt_r == 4'd1) begin
               state_s    = IDLE;
               ring_cnt_s = 4'd0;
            end else begin
               if (minute_edge_s) begin
                  ring_cnt_s = ring_cnt_r - 4'd1;
               end else begin
                  ring_cnt_s = ring_cnt_r;
               end
               if (beep_cnt_r == BEEP_LAST) begin
                  beep_cnt_s = '0;
                  buzzer_s   = ~buzzer_r;
               end else begin
                  beep_cnt_s = beep_cnt_r + BEEP_ONE;
                  buzzer_s   = buzzer_r;
               end
            end
         end
         SNOOZE: begin
            if (do_stop_s) begin
               state_s = IDLE;
            end else if (minute_edge_s && snooze_cnt_r == 4'd1) begin
               state_s      = RINGING;
               snooze_cnt_s = 4'd0;
               ring_cnt_s   = 4'(RING_MIN);
               beep_cnt_s   = '0;
               buzzer_s     = 1'b1;
            end else if (minute_edge_s) begin
               snooze_cnt_s = snooze_cnt_r - 4'd1;
            end else begin
               state_s = SNOOZE;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State, alarm time and timing registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r      <= IDLE;
         ahd_r        <= INIT_HD;
         aho_r        <= INIT_HO;
         amd_r        <= INIT_MD;
         amo_r        <= INIT_MO;
         en_r         <= 1'b0;
         ring_cnt_r   <= 4'd0;
         snooze_cnt_r <= 4'd0;
         beep_cnt_r   <= '0;
         buzzer_r     <= 1'b0;
         minone_d_r   <= 4'd0;
         valid_r      <= 1'b0;
         match_d_r    <= 1'b0;
      end else begin
         state_r      <= state_s;
         ahd_r        <= ahd_s;
         aho_r        <= aho_s;
         amd_r        <= amd_s;
         amo_r        <= amo_s;
         en_r         <= en_s;
         ring_cnt_r   <= ring_cnt_s;
         snooze_cnt_r <= snooze_cnt_s;
         beep_cnt_r   <= beep_cnt_s;
         buzzer_r     <= buzzer_s;
         minone_d_r   <= minone_now;
         valid_r      <= 1'b1;
         match_d_r    <= match_s;
      end
   end

   assign alarm_hourdec = ahd_r;
   assign alarm_hourone = aho_r;
   assign alarm_mindec  = amd_r;
   assign alarm_minone  = amo_r;
   assign alarm_en      = en_r;
   assign buzzer        = buzzer_r;
   assign disp_sel      = (state_r == SET_HOUR) || (state_r == SET_MIN);
   assign blink_hour    = (state_r == SET_HOUR);
   assign blink_min     = (state_r == SET_MIN);
   assign ringing       = (state_r == RINGING) || (state_r == SNOOZE);

endmodule

// File: tb/tb_alarm_ctrl.sv
// Randomised and directed bench for alarm_ctrl against an integer-time behavioural model.
`timescale 1ns/1ps
module tb_alarm_ctrl;

   localparam int BEEP = 4;
   localparam int SNZ  = 5;
   localparam int RNG  = 1;
   localparam int M_IDLE = 0, M_SETH = 1, M_SETM = 2, M_RING = 3, M_SNZ = 4;
   localparam int B_SET = 0, B_INC = 1, B_ARM = 2, B_STOP = 3, B_SNZ = 4;

   logic clk = 1'b0;
   logic rstn = 1'b1;
   logic [4:0] b_v = 5'd0;
   int t_h = 12, t_m = 0;
   logic [3:0] hourdec_now, hourone_now, mindec_now, minone_now;
   logic [3:0] alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone;
   logic alarm_en, disp_sel, blink_hour, blink_min, buzzer, ringing;

   int n_cmp = 0, n_err = 0;
   bit chk_on = 1'b0;

   // model state: alarm as integer hour/minute, ring phase as elapsed cycles
   int m_mode, m_ah, m_am, m_left, m_age, m_pmin;
   bit m_en, m_valid, m_matchd;
   logic [4:0] m_prev;

   always #5 clk = ~clk;

   assign hourdec_now = 4'(t_h / 10);
   assign hourone_now = 4'(t_h % 10);
   assign mindec_now  = 4'(t_m / 10);
   assign minone_now  = 4'(t_m % 10);

   alarm_ctrl #(
      .ALARM_INIT_HOUR (7),
      .ALARM_INIT_MIN  (0),
      .SNOOZE_MIN      (SNZ),
      .RING_MIN        (RNG),
      .BEEP_CYC        (BEEP)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .hourdec_now   (hourdec_now),
      .hourone_now   (hourone_now),
      .mindec_now    (mindec_now),
      .minone_now    (minone_now),
      .btn_set       (b_v[B_SET]),
      .btn_inc       (b_v[B_INC]),
      .btn_arm       (b_v[B_ARM]),
      .btn_stop      (b_v[B_STOP]),
      .btn_snooze    (b_v[B_SNZ]),
      .alarm_hourdec (alarm_hourdec),
      .alarm_hourone (alarm_hourone),
      .alarm_mindec  (alarm_mindec),
      .alarm_minone  (alarm_minone),
      .alarm_en      (alarm_en),
      .disp_sel      (disp_sel),
      .blink_hour    (blink_hour),
      .blink_min     (blink_min),
      .buzzer        (buzzer),
      .ringing       (ringing)
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_ah = 7; m_am = 0; m_en = 1'b0;
      m_left = 0; m_age = 0; m_pmin = 0;
      m_valid = 1'b0; m_matchd = 1'b0; m_prev = 5'b11111;
   endtask

   task automatic start_ring();
      m_mode = M_RING; m_left = RNG; m_age = 0;
   endtask

   // One clock of the rules, using the inputs present during that cycle.
   task automatic model_step();
      logic [4:0] pr;
      int act, mo;
      bit medge, match, trig;
      pr = b_v & ~m_prev;
      m_prev = b_v;
      mo = t_m % 10;
      medge = m_valid && (mo != m_pmin);
      m_pmin = mo;
      m_valid = 1'b1;
      match = m_en && (t_h == m_ah) && (t_m == m_am);
      trig = match && !m_matchd;
      m_matchd = match;
      if (pr[B_STOP]) act = B_STOP;
      else if (pr[B_SNZ]) act = B_SNZ;
      else if (pr[B_SET]) act = B_SET;
      else if (pr[B_INC]) act = B_INC;
      else if (pr[B_ARM]) act = B_ARM;
      else act = -1;
      case (m_mode)
         M_IDLE: begin
            if (trig) start_ring();
            else if (act == B_SET) m_mode = M_SETH;
            else if (act == B_ARM) m_en = !m_en;
         end
         M_SETH: begin
            if (act == B_SET) m_mode = M_SETM;
            else if (act == B_INC) m_ah = (m_ah + 1) % 24;
         end
         M_SETM: begin
            if (act == B_SET) m_mode = M_IDLE;
            else if (act == B_INC) m_am = (m_am + 1) % 60;
         end
         M_RING: begin
            if (act == B_STOP) m_mode = M_IDLE;
            else if (act == B_SNZ) begin m_mode = M_SNZ; m_left = SNZ; end
            else begin
               if (medge) m_left--;
               if (medge && m_left == 0) m_mode = M_IDLE;
               else m_age++;
            end
         end
         M_SNZ: begin
            if (act == B_STOP) m_mode = M_IDLE;
            else if (medge) begin
               m_left--;
               if (m_left == 0) start_ring();
            end
         end
         default: m_mode = M_IDLE;
      endcase
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (rstn) model_step();
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int idx);
      b_v[idx] = 1'b1; cyc(1);
      b_v[idx] = 1'b0; cyc(1);
   endtask

   task automatic do_reset();
      #2;
      rstn = 1'b0;
      model_reset();
      #1;
      check("rst_buzzer", buzzer, 0);
      check("rst_ringing", ringing, 0);
      check("rst_disp_sel", disp_sel, 0);
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   // Every-cycle comparison of all outputs against the model.
   always @(posedge clk) begin
      #1;
      if (chk_on) begin
         check("alarm_hourdec", alarm_hourdec, m_ah / 10);
         check("alarm_hourone", alarm_hourone, m_ah % 10);
         check("alarm_mindec", alarm_mindec, m_am / 10);
         check("alarm_minone", alarm_minone, m_am % 10);
         check("alarm_en", alarm_en, m_en);
         check("disp_sel", disp_sel, (m_mode == M_SETH || m_mode == M_SETM) ? 1 : 0);
         check("blink_hour", blink_hour, (m_mode == M_SETH) ? 1 : 0);
         check("blink_min", blink_min, (m_mode == M_SETM) ? 1 : 0);
         check("ringing", ringing, (m_mode == M_RING || m_mode == M_SNZ) ? 1 : 0);
         check("buzzer", buzzer, (m_mode == M_RING && ((m_age / BEEP) % 2 == 0)) ? 1 : 0);
      end
   end

   initial begin
      int tm;
      // reset with btn_set held: no press until it falls and rises again
      b_v[B_SET] = 1'b1;
      do_reset();
      chk_on = 1'b1;
      check("lit_rst_hourdec", alarm_hourdec, 0);
      check("lit_rst_hourone", alarm_hourone, 7);
      check("lit_rst_min", {alarm_mindec, alarm_minone}, 0);
      check("lit_rst_en", alarm_en, 0);
      cyc(3);
      check("lit_held_set", disp_sel, 0);
      b_v[B_SET] = 1'b0; cyc(1);
      b_v[B_SET] = 1'b1; cyc(1);
      check("lit_set_hour", blink_hour, 1);
      b_v[B_SET] = 1'b0; cyc(1);

      // hour 07 -> 23 -> 00, minute 00 -> 59 -> 00 -> 01
      repeat (16) press(B_INC);
      check("lit_hour23", {alarm_hourdec, alarm_hourone}, 8'h23);
      press(B_INC);
      check("lit_hour00", {alarm_hourdec, alarm_hourone}, 8'h00);
      press(B_SET);
      check("lit_set_min", blink_min, 1);
      repeat (61) press(B_INC);
      press(B_SET);
      check("lit_alarm_0001", {alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}, 16'h0001);
      check("lit_idle_disp", disp_sel, 0);

      // program 06:30, arm, ring with 4-cycle beep half-period
      press(B_SET);
      repeat (6) press(B_INC);
      press(B_SET);
      repeat (29) press(B_INC);
      press(B_SET);
      check("lit_alarm_0630", {alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}, 16'h0630);
      press(B_ARM);
      check("lit_armed", alarm_en, 1);
      t_h = 6; t_m = 29; cyc(2);
      t_m = 30; cyc(1);
      check("lit_ring_entry", ringing, 1);
      check("lit_buzz_on", buzzer, 1);
      cyc(3);
      check("lit_buzz_still_on", buzzer, 1);
      cyc(1);
      check("lit_buzz_off", buzzer, 0);
      cyc(4);

      // snooze for five minute boundaries
      press(B_SNZ);
      check("lit_snooze_buzz", buzzer, 0);
      for (int m = 31; m <= 35; m++) begin
         t_m = m; cyc(3);
         if (m < 35) check("lit_snoozing", buzzer, 0);
      end
      check("lit_resnooze_ring", buzzer, 1);

      // one-minute ring timeout, then stop without re-trigger
      t_m = 36; cyc(1);
      check("lit_timeout", ringing, 0);
      check("lit_timeout_en", alarm_en, 1);
      t_m = 30; cyc(1);
      check("lit_ring_again", ringing, 1);
      press(B_STOP);
      cyc(10);
      check("lit_no_retrigger", ringing, 0);

      // disarmed alarm does not ring
      press(B_ARM);
      t_m = 31; cyc(2);
      t_m = 30; cyc(3);
      check("lit_disarmed", ringing, 0);

      // trigger beats a simultaneous set press
      t_m = 31; cyc(1);
      press(B_ARM);
      t_m = 30; b_v[B_SET] = 1'b1; cyc(1);
      check("lit_trig_wins", ringing, 1);
      check("lit_trig_no_set", disp_sel, 0);
      b_v[B_SET] = 1'b0; cyc(3);

      // asynchronous reset mid-ring
      do_reset();
      cyc(2);
      check("lit_rst2_alarm", {alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone}, 16'h0700);

      // randomized phase
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < 5; i++) b_v[i] = ($urandom_range(5) == 0);
         case ($urandom_range(99))
            0, 1, 2, 3: begin
               t_m = t_m + 1;
               if (t_m == 60) begin t_m = 0; t_h = (t_h + 1) % 24; end
            end
            4: begin
               tm = (m_ah * 60 + m_am + 1439) % 1440;
               t_h = tm / 60; t_m = tm % 60;
            end
            5: begin
               t_h = m_ah; t_m = m_am;
            end
            default: ;
         endcase
         cyc(1);
      end

      b_v = 5'd0;
      cyc(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alarm_ctrl.md
Name: alarm_ctrl

Overview:
- Consumes the BCD time digits (hourdec/hourone/mindec/minone) produced by the watch counter. Holds a user-settable alarm time and compares it against current time.
- Drives a pulsed buzzer, with stop, snooze and automatic ring timeout.
- Provides the alarm digits and a display-select flag, so the 7-segment mux can show the alarm time while it is being set.

Parameters:
- ALARM_INIT_HOUR, 7, alarm hour after reset (0..23, binary; converted to BCD internally).
- ALARM_INIT_MIN, 0, alarm minute after reset (0..59).
- SNOOZE_MIN, 5, minute boundaries counted in SNOOZE before re-ringing (1..15).
- RING_MIN, 1, minute boundaries counted in RINGING before auto-stop (1..15).
- BEEP_CYC, 25000000, clk cycles per buzzer toggle half-period (>=1).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- hourdec_now  in  4  current hour tens, BCD 0..2
- hourone_now  in  4  current hour units, BCD 0..9
- mindec_now  in  4  current minute tens, BCD 0..5
- minone_now  in  4  current minute units, BCD 0..9
- btn_set  in  1  debounced, clk-synchronous level; rising edge = press
- btn_inc  in  1  increment field being set
- btn_arm  in  1  toggle alarm_en (only in IDLE)
- btn_stop  in  1  stop ringing/snooze
- btn_snooze  in  1  snooze while ringing
- alarm_hourdec  out  4  alarm hour tens
- alarm_hourone  out  4  alarm hour units
- alarm_mindec  out  4  alarm minute tens
- alarm_minone  out  4  alarm minute units
- alarm_en  out  1  alarm armed
- disp_sel  out  1  1 = display should show alarm digits
- blink_hour  out  1  1 in SET_HOUR
- blink_min  out  1  1 in SET_MIN
- buzzer  out  1  buzzer drive
- ringing  out  1  1 in RINGING or SNOOZE

Behaviour:
- Reset, asynchronous:
  - Alarm digits = BCD of ALARM_INIT_HOUR:ALARM_INIT_MIN (07:00).
  - alarm_en=0, state=IDLE, buzzer=0, disp_sel=0, blink_*=0, ringing=0.
  - All counters 0.
  - Button edge registers reset to 1, so a button held through reset gives no press.
  - Minute-edge valid flag reset to 0.
- Press detect:
  - press_x = btn_x & ~btn_x_d. The FSM acts on the same clock edge (1-cycle latency from sampled rise).
  - Only one action per cycle. Priority: stop > snooze > set > inc > arm.
- Minute boundary:
  - minute_edge = valid & (minone_now != minone_d).
  - valid is set 1 cycle after reset; no edge is reported before then.
- Match:
  - match = alarm_en & all four digit pairs equal.
  - trigger = match & ~match_d. Fires once per matching minute; it cannot re-fire within that minute after stop.
- IDLE:
  - press_set -> SET_HOUR.
  - press_arm toggles alarm_en.
  - trigger -> RINGING, loading ring_cnt=RING_MIN and beep_cnt=0, with buzzer=1.
  - If trigger and press_set occur in the same cycle, trigger wins.
- SET_HOUR:
  - disp_sel=1, blink_hour=1.
  - press_inc: hour +1 in BCD; 09->10, 19->20, 23->00.
  - press_set -> SET_MIN.
  - trigger is ignored; match_d still updates.
- SET_MIN:
  - disp_sel=1, blink_min=1.
  - press_inc: minute +1 in BCD; 09->10, 59->00, with no carry into hour.
  - press_set -> IDLE.
  - Changing the alarm to the current time while in a SET state does not ring, since match_d is already 1 on return.
- RINGING:
  - buzzer toggles when beep_cnt reaches BEEP_CYC-1; beep_cnt then wraps to 0.
  - minute_edge decrements ring_cnt. Reaching 0 -> IDLE.
  - press_stop -> IDLE.
  - press_snooze -> SNOOZE with snooze_cnt=SNOOZE_MIN.
  - alarm_en is unchanged by any exit.
- SNOOZE:
  - buzzer=0, ringing=1.
  - minute_edge decrements snooze_cnt. Reaching 0 -> RINGING, reloading ring_cnt and restarting beep with buzzer=1.
  - press_stop -> IDLE.
- General:
  - buzzer=0 in every state except RINGING.
  - press_arm is ignored outside IDLE.
  - rstn assertion in any state returns everything to reset values immediately.
- Widths:
  - Counters are 4-bit for ring/snooze.
  - beep_cnt width is $clog2(BEEP_CYC+1).

Decomposition:
- Package alarm_pkg:
  - enum alarm_state_t {IDLE, SET_HOUR, SET_MIN, RINGING, SNOOZE}, 3 bits.
  - BCD limit constants (HOUR_TENS_MAX=2, HOUR_WRAP_UNITS=3, MIN_TENS_MAX=5, UNITS_MAX=9).
- Sub-module btn_edge, parameter N=5:
  - N-wide rising-edge detector, registered previous values reset to 1.
  - Instantiated once for all buttons.

Test Plan:
- Reset with btn_set held high -> state IDLE, alarm 07:00, alarm_en=0, no SET_HOUR entry until btn_set falls and rises again.
- press_set; press_inc x17; press_set; press_inc x61; press_set -> alarm 00:01 (hour 07->23->00, minute 00->59->00->01); disp_sel=1 only during both SET states.
- alarm_en=1, alarm 06:30, drive time 06:29 then 06:30 -> RINGING next cycle, buzzer=1; with BEEP_CYC=4, buzzer toggles every 4 cycles.
- Ringing at 06:30, press_snooze, SNOOZE_MIN=5: time steps 06:31..06:35 -> buzzer 0 throughout SNOOZE, RINGING re-entered on the 06:35 edge.
- RINGING, RING_MIN=1, no buttons: time 06:30->06:31 -> IDLE, buzzer=0, alarm_en still 1; holding 06:30 after stop does not re-trigger.
- alarm_en=0 with matching time -> no ring. trigger and press_set in the same cycle -> RINGING. rstn pulse mid-RINGING -> buzzer=0 and IDLE asynchronously.
